// File: rtl/exe_mem_stage_reg.sv
// rtl/exe_mem_stage_reg.sv - EXE/MEM pipeline register with valid/ready handshake and flush.
// Define EXE_MEM_SKID_EN to add a one-entry skid buffer that registers in_ready.
module exe_mem_stage_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] exe_result,
  input  logic [ADDR_W-1:0] exe_branch_addr,
  input  logic [REG_W-1:0]  exe_dst_reg,
  input  logic [REG_W-1:0]  exe_rd,
  input  logic              exe_zero,
  input  logic              branch_eq_in,
  input  logic              branch_ne_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] mem_result,
  output logic [ADDR_W-1:0] mem_branch_addr,
  output logic [REG_W-1:0]  mem_dst_reg,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_zero,
  output logic              branch_eq_out,
  output logic              branch_ne_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              mem_to_reg_out,
  output logic              reg_write_out,
  output logic              branch_taken
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [ADDR_W-1:0] baddr;
    logic [REG_W-1:0]  dst;
    logic [REG_W-1:0]  rd;
    logic              zero;
    logic              beq;
    logic              bne;
    logic              mrd;
    logic              mwr;
    logic              m2r;
    logic              rw;
  } entry_t;

  entry_t in_entry;
  entry_t out_q, out_d;
  logic   out_valid_q, out_valid_d;
  logic   in_fire;
  logic   out_fire;

  assign in_entry = {exe_result, exe_branch_addr, exe_dst_reg, exe_rd, exe_zero,
                     branch_eq_in, branch_ne_in, mem_read_in, mem_write_in,
                     mem_to_reg_in, reg_write_in};
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;

`ifdef EXE_MEM_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_valid_q, skid_valid_d;

  // in_ready depends only on skid state (and flush), never on out_ready.
  assign in_ready = flush | ~skid_valid_q;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q) begin
      if (in_fire) begin
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end
    end else if (out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d = in_entry;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign in_ready = flush | ~out_valid_q | out_ready;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_fire) begin
      out_d       = in_entry;
      out_valid_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign mem_result      = out_q.result;
  assign mem_branch_addr = out_q.baddr;
  assign mem_dst_reg     = out_q.dst;
  assign mem_rd          = out_q.rd;
  assign mem_zero        = out_q.zero;
  // Controls are masked so a stale entry can never trigger a memory or register write.
  assign branch_eq_out   = out_valid_q & out_q.beq;
  assign branch_ne_out   = out_valid_q & out_q.bne;
  assign mem_read_out    = out_valid_q & out_q.mrd;
  assign mem_write_out   = out_valid_q & out_q.mwr;
  assign mem_to_reg_out  = out_valid_q & out_q.m2r;
  assign reg_write_out   = out_valid_q & out_q.rw;
  assign branch_taken    = out_valid_q & ((out_q.beq & out_q.zero) | (out_q.bne & ~out_q.zero));

endmodule

// File: tb/tb_exe_mem_stage_reg.sv
// tb/tb_exe_mem_stage_reg.sv - self-checking bench for exe_mem_stage_reg (both EXE_MEM_SKID_EN builds).
module tb_exe_mem_stage_reg;

`ifdef EXE_MEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] exe_result, exe_branch_addr, mem_result, mem_branch_addr;
  logic [4:0]  exe_dst_reg, exe_rd, mem_dst_reg, mem_rd;
  logic        exe_zero, branch_eq_in, branch_ne_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in;
  logic        mem_zero, branch_eq_out, branch_ne_out, mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out;
  logic        branch_taken;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exe_mem_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .exe_result(exe_result), .exe_branch_addr(exe_branch_addr), .exe_dst_reg(exe_dst_reg),
    .exe_rd(exe_rd), .exe_zero(exe_zero), .branch_eq_in(branch_eq_in), .branch_ne_in(branch_ne_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
    .reg_write_in(reg_write_in), .out_valid(out_valid), .out_ready(out_ready),
    .mem_result(mem_result), .mem_branch_addr(mem_branch_addr), .mem_dst_reg(mem_dst_reg),
    .mem_rd(mem_rd), .mem_zero(mem_zero), .branch_eq_out(branch_eq_out),
    .branch_ne_out(branch_ne_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out), .branch_taken(branch_taken)
  );

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] baddr;
    logic [4:0]  dst;
    logic [4:0]  rd;
    logic        zero, beq, bne, mrd, mwr, m2r, rw;
  } ent_t;

  // Reference model: an ordered queue of in-flight instructions bounded by CAP.
  ent_t q[$];
  ent_t last_head;

  typedef struct {
    logic        iv;
    logic [31:0] res;
    logic        bne;
    logic        zero;
    logic        exp_ov;
    logic [31:0] exp_res;
    logic        exp_bt;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic model_in_ready();
    if (flush) return 1'b1;
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  function automatic ent_t cur_in();
    return {exe_result, exe_branch_addr, exe_dst_reg, exe_rd, exe_zero, branch_eq_in,
            branch_ne_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in};
  endfunction

  task automatic check_all(input string tag);
    logic v;
    ent_t h;
    v = q.size() > 0;
    h = last_head;
    chk({tag, ".in_ready"}, in_ready, model_in_ready());
    chk({tag, ".out_valid"}, out_valid, v);
    chk({tag, ".mem_result"}, mem_result, h.result);
    chk({tag, ".mem_branch_addr"}, mem_branch_addr, h.baddr);
    chk({tag, ".dst_rd"}, {mem_dst_reg, mem_rd}, {h.dst, h.rd});
    chk({tag, ".mem_zero"}, mem_zero, h.zero);
    chk({tag, ".ctrl"}, {branch_eq_out, branch_ne_out, mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out},
        {v & h.beq, v & h.bne, v & h.mrd, v & h.mwr, v & h.m2r, v & h.rw});
    chk({tag, ".branch_taken"}, branch_taken, v & ((h.beq & h.zero) | (h.bne & ~h.zero)));
  endtask

  task automatic tick(input string tag);
    ent_t nq[$];
    ent_t nl;
    logic ir;
    nq = q;
    nl = last_head;
    ir = model_in_ready();
    if (rst) begin
      nq = {};
      nl = '0;
    end else if (flush) begin
      nq = {};
    end else begin
      logic fo;
      fo = (nq.size() > 0) && out_ready;
      if (fo) void'(nq.pop_front());
      if (in_valid && ir) nq.push_back(cur_in());
      if (nq.size() > 0) nl = nq[0];
    end
    @(posedge clk);
    q = nq;
    last_head = nl;
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    exe_result = 0; exe_branch_addr = 0; exe_dst_reg = 0; exe_rd = 0; exe_zero = 0;
    branch_eq_in = 0; branch_ne_in = 0; mem_read_in = 0; mem_write_in = 0;
    mem_to_reg_in = 0; reg_write_in = 0;
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1, 32'd1, 0, 0, 1, 32'd1, 0};
    tbl[1] = '{1, 32'd2, 0, 0, 1, 32'd2, 0};
    tbl[2] = '{1, 32'd3, 0, 0, 1, 32'd3, 0};
    tbl[3] = '{1, 32'd4, 1, 0, 1, 32'd4, 1};
    tbl[4] = '{1, 32'd5, 1, 1, 1, 32'd5, 0};
    tbl[5] = '{0, 32'd0, 0, 0, 0, 32'd5, 0};
    tbl[6] = '{1, 32'd7, 1, 0, 1, 32'd7, 1};
    tbl[7] = '{0, 32'd0, 0, 0, 0, 32'd7, 0};

    q = {};
    last_head = '0;

    // Reset with a live incoming instruction.
    idle();
    rst = 1; in_valid = 1; exe_result = 32'hDEAD_BEEF; mem_write_in = 1; reg_write_in = 1;
    tick("reset");
    chk("reset.out_valid", out_valid, 0);
    chk("reset.in_ready", in_ready, 1);
    chk("reset.mem_result", mem_result, 0);
    chk("reset.ctrl", {mem_write_out, reg_write_out, branch_taken}, 0);

    // Streaming and branch resolution table.
    idle();
    for (int i = 0; i < 8; i++) begin
      in_valid = tbl[i].iv; exe_result = tbl[i].res;
      branch_ne_in = tbl[i].bne; exe_zero = tbl[i].zero; out_ready = 1;
      tick("stream");
      chk($sformatf("tbl%0d.out_valid", i), out_valid, tbl[i].exp_ov);
      chk($sformatf("tbl%0d.mem_result", i), mem_result, tbl[i].exp_res);
      chk($sformatf("tbl%0d.branch_taken", i), branch_taken, tbl[i].exp_bt);
    end

    // Backpressure with a second instruction waiting.
    idle();
    in_valid = 1; exe_result = 5;
    tick("bp_load");
    chk("bp.first", mem_result, 5);
    out_ready = 0; exe_result = 6;
    for (int i = 0; i < 3; i++) begin
      tick("bp_stall");
      chk("bp.hold_valid", out_valid, 1);
      chk("bp.hold_result", mem_result, 5);
`ifdef EXE_MEM_SKID_EN
      in_valid = 0;
`endif
    end
    #1 chk("bp.in_ready_low", in_ready, 0);
    out_ready = 1;
    tick("bp_drain");
    chk("bp.second_valid", out_valid, 1);
    chk("bp.second_result", mem_result, 6);
    in_valid = 0;
    tick("bp_empty");
    chk("bp.empty", out_valid, 0);

    // Flush kills the held entry and the incoming one.
    idle();
    out_ready = 0; in_valid = 1; exe_result = 32'h11; mem_write_in = 1;
    tick("fl_load");
    chk("flush.pre_mwr", mem_write_out, 1);
    flush = 1; exe_result = 32'h99;
    #1 chk("flush.in_ready", in_ready, 1);
    tick("fl_cyc");
    chk("flush.out_valid", out_valid, 0);
    chk("flush.mem_write_out", mem_write_out, 0);
    chk("flush.payload_held", mem_result, 32'h11);
    flush = 0; in_valid = 0; out_ready = 1;
    tick("fl_after");
    tick("fl_after");
    chk("flush.no_ghost", out_valid, 0);

    // Reset during a full stall.
    idle();
    out_ready = 0; in_valid = 1; exe_result = 32'hA1;
    tick("rs_fill");
    exe_result = 32'hA2;
    tick("rs_fill");
    in_valid = 0; rst = 1;
    tick("rs_rst");
    rst = 0; out_ready = 1;
    for (int i = 0; i < 3; i++) tick("rs_after");
    chk("rststall.out_valid", out_valid, 0);
    chk("rststall.mem_result", mem_result, 0);

    // Randomized traffic against the queue model.
    idle();
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 63) == 0);
      flush           = ($urandom_range(0, 15) == 0);
      in_valid        = $urandom_range(0, 2) != 0;
      out_ready       = $urandom_range(0, 2) != 0;
      exe_result      = $urandom;
      exe_branch_addr = $urandom;
      exe_dst_reg     = 5'($urandom);
      exe_rd          = 5'($urandom);
      {exe_zero, branch_eq_in, branch_ne_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in} = 7'($urandom);
      #1 check_all("rnd_pre");
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
